fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle IF/ID/EX/MEM/WB sequencer with PC update; option macro FETCH_MISALIGN_TRAP_EN
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_data_read,
  input  logic        i_ready,
  input  logic        mem_access,
  input  logic        d_ready,
  input  logic [1:0]  pc_cmd,
  input  logic        pc_rel,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic [31:0] i_address,
  output logic        i_read,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        if_stage,
  output logic        id_stage,
  output logic        ex_stage,
  output logic        mem_stage,
  output logic        wb_stage,
  output logic        trap
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] S_TRAP = 3'd5;
`endif

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        taken;

  assign pc_plus4  = pc + 32'd4;
  assign i_address = pc;

  assign if_stage  = (state == S_IF);
  assign id_stage  = (state == S_ID);
  assign ex_stage  = (state == S_EX);
  assign mem_stage = (state == S_MEM);
  assign wb_stage  = (state == S_WB);
  assign i_read    = if_stage;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap = (state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

  // Branch decision and target; only consumed while in WB
  always_comb begin
    taken  = (pc_cmd == 2'b11)
           | ((pc_cmd == 2'b01) && (rs1_val == 32'd0))
           | ((pc_cmd == 2'b10) && (rs1_val != 32'd0));
    target = pc_rel ? (pc_plus4 + imm) : rs1_val;
  end

  // Stage sequencing, instruction latch and PC update at the end of WB
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IF;
      pc    <= RESET_PC;
      instr <= 32'd0;
    end else begin
      case (state)
        S_IF: begin
          if (i_ready) begin
            instr <= i_data_read;
            state <= S_ID;
          end
        end
        S_ID:  state <= S_EX;
        S_EX:  state <= S_MEM;
        S_MEM: begin
          if (!mem_access || d_ready) state <= S_WB;
        end
        S_WB: begin
          state <= S_IF;
          if (!taken) begin
            pc <= pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
          end else if (target[1:0] != 2'b00) begin
            // Misaligned target: keep pc for post-mortem, park until reset
            state <= S_TRAP;
          end else begin
            pc <= target;
          end
`else
          end else begin
            pc <= target & 32'hFFFF_FFFC;
          end
`endif
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_IF;
      endcase
    end
  end

endmodule
